// File: rtl/spi_slave_link.sv
// -----------------------------------------------------------------------------
// spi_slave_link
// SPI mode-0 (CPOL=0, CPHA=0) slave endpoint. SCLK, SS_N and MOSI are
// oversampled in the I_CLK domain; one DATA_WIDTH-bit word is shifted in each
// direction per word slot, MSB first, with back-to-back words per frame.
//
// Optional feature macro: SPI_SLAVE_OVERRUN_EN
//   defined   : a word completing while O_RX_VALID=1 is dropped and sets the
//               sticky O_OVERRUN; I_RX_ACK clears O_RX_VALID and O_OVERRUN.
//   undefined : every completed word overwrites O_RX_DATA; O_OVERRUN = 0.
//
// Ports
//   I_CLK        system clock, rising edge
//   I_RESET      synchronous active-high reset
//   I_SCLK       SPI clock from master (async, idle low)
//   I_SS_N       slave select, active low (async)
//   I_MOSI       master-out data (async)
//   O_MISO       slave-out data, registered
//   I_TX_DATA    word to return to the master
//   I_TX_LOAD    one-cycle write strobe for I_TX_DATA
//   O_TX_READY   TX holding register empty
//   O_RX_DATA    last completed received word, held
//   O_RX_VALID   O_RX_DATA unread (level)
//   I_RX_ACK     one-cycle strobe clearing O_RX_VALID
//   O_OVERRUN    sticky overrun flag (0 unless SPI_SLAVE_OVERRUN_EN)
//   O_BUSY       frame in progress
// -----------------------------------------------------------------------------
module spi_slave_link #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic                  I_SCLK,
  input  logic                  I_SS_N,
  input  logic                  I_MOSI,
  output logic                  O_MISO,
  input  logic [DATA_WIDTH-1:0] I_TX_DATA,
  input  logic                  I_TX_LOAD,
  output logic                  O_TX_READY,
  output logic [DATA_WIDTH-1:0] O_RX_DATA,
  output logic                  O_RX_VALID,
  input  logic                  I_RX_ACK,
  output logic                  O_OVERRUN,
  output logic                  O_BUSY
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Synchronizer stages packed as {sclk, ss_n, mosi}; history only for the
  // two signals whose edges are detected. MOSI is taken from the second
  // stage so it lines up with the synchronized SCLK used for detection.
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [1:0] r_hist;

  logic                  r_miso;
  logic [DATA_WIDTH-2:0] r_tx_shift;   // bits below the one on O_MISO
  logic [DATA_WIDTH-1:0] r_tx_hold;
  logic                  r_tx_ready;
  logic [DATA_WIDTH-2:0] r_rx_shift;   // bits collected so far in this word
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic [CW-1:0]         r_cnt;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic                  r_overrun;
`endif

  logic w_sclk, w_ss_n, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic w_enter, w_leave, w_rise_ev, w_fall_ev;
  logic w_xfer, w_shift_out, w_accept, w_last_bit;
  logic [DATA_WIDTH-1:0] w_load_word;
  logic [DATA_WIDTH-1:0] w_rx_word;

  assign w_sclk = r_sync2[2];
  assign w_ss_n = r_sync2[1];
  assign w_mosi = r_sync2[0];

  assign w_sclk_rise =  w_sclk & ~r_hist[1];
  assign w_sclk_fall = ~w_sclk &  r_hist[1];
  assign w_ss_fall   = ~w_ss_n &  r_hist[0];
  assign w_ss_rise   =  w_ss_n & ~r_hist[0];

  // Next-state logic and per-cycle event qualification.
  always_comb begin
    w_state_next = r_state;
    w_enter      = 1'b0;
    w_leave      = 1'b0;
    w_rise_ev    = 1'b0;
    w_fall_ev    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_state_next = ST_SHIFT;
          w_enter      = 1'b1;
        end
      end
      ST_SHIFT: begin
        // Deselect takes priority over any SCLK edge seen in the same cycle.
        if (w_ss_rise) begin
          w_state_next = ST_IDLE;
          w_leave      = 1'b1;
        end else begin
          w_rise_ev = w_sclk_rise;
          w_fall_ev = w_sclk_fall;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // A counter of zero on a falling edge can only follow a completed word,
  // because the first falling edge of a frame comes after at least one rise.
  assign w_xfer      = w_enter | (w_fall_ev && (r_cnt == '0));
  assign w_shift_out = w_fall_ev && (r_cnt != '0);
  assign w_load_word = r_tx_ready ? '0 : r_tx_hold;

  // A load is taken when the holding register is empty, or when it is being
  // emptied into the shift register in this very cycle (old value moves out,
  // new value moves in, holding stays full).
  assign w_accept    = I_TX_LOAD & (r_tx_ready | w_xfer);

  assign w_rx_word   = {r_rx_shift, w_mosi};
  assign w_last_bit  = w_rise_ev && (r_cnt == LAST_BIT);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state    <= ST_IDLE;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_hist     <= '0;
      r_miso     <= 1'b0;
      r_tx_shift <= '0;
      r_tx_hold  <= '0;
      r_tx_ready <= 1'b1;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_cnt      <= '0;
`ifdef SPI_SLAVE_OVERRUN_EN
      r_overrun  <= 1'b0;
`endif
    end else begin
      r_sync1 <= {I_SCLK, I_SS_N, I_MOSI};
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2[2:1];
      r_state <= w_state_next;

      // Transmit path
      if (w_xfer) begin
        r_miso     <= w_load_word[DATA_WIDTH-1];
        r_tx_shift <= w_load_word[DATA_WIDTH-2:0];
      end else if (w_shift_out) begin
        r_miso     <= r_tx_shift[DATA_WIDTH-2];
        r_tx_shift <= {r_tx_shift[DATA_WIDTH-3:0], 1'b0};
      end else if (w_leave) begin
        r_miso     <= 1'b0;
      end

      if (w_accept) begin
        r_tx_hold <= I_TX_DATA;
      end
      r_tx_ready <= w_accept ? 1'b0 : (w_xfer ? 1'b1 : r_tx_ready);

      // Receive path; an aborted frame simply drops the partial word.
      if (w_leave) begin
        r_cnt <= '0;
      end else if (w_rise_ev) begin
        r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
        r_cnt      <= w_last_bit ? '0 : r_cnt + CW'(1);
      end

`ifdef SPI_SLAVE_OVERRUN_EN
      if (I_RX_ACK) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end
      if (w_last_bit) begin
        if (r_rx_valid && !I_RX_ACK) begin
          r_overrun <= 1'b1;
        end else begin
          r_rx_data  <= w_rx_word;
          r_rx_valid <= 1'b1;
        end
      end
`else
      if (w_last_bit) begin
        r_rx_data  <= w_rx_word;
        r_rx_valid <= 1'b1;
      end else if (I_RX_ACK) begin
        r_rx_valid <= 1'b0;
      end
`endif
    end
  end

  assign O_MISO     = r_miso;
  assign O_TX_READY = r_tx_ready;
  assign O_RX_DATA  = r_rx_data;
  assign O_RX_VALID = r_rx_valid;
  assign O_BUSY     = (r_state == ST_SHIFT);
`ifdef SPI_SLAVE_OVERRUN_EN
  assign O_OVERRUN  = r_overrun;
`else
  assign O_OVERRUN  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_link.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_link
// Drives spi_slave_link as an SPI mode-0 master with SCLK = I_CLK/16 and
// checks it against a word-level model of the holding register, the RX
// handshake and (when SPI_SLAVE_OVERRUN_EN is defined) the overrun rule.
// -----------------------------------------------------------------------------
module tb_spi_slave_link;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         I_RESET;
  logic         I_SCLK;
  logic         I_SS_N;
  logic         I_MOSI;
  logic         O_MISO;
  logic [W-1:0] I_TX_DATA;
  logic         I_TX_LOAD;
  logic         O_TX_READY;
  logic [W-1:0] O_RX_DATA;
  logic         O_RX_VALID;
  logic         I_RX_ACK;
  logic         O_OVERRUN;
  logic         O_BUSY;

  always #5 clk = ~clk;

  spi_slave_link #(.DATA_WIDTH(W)) dut (
    .I_CLK      (clk),
    .I_RESET    (I_RESET),
    .I_SCLK     (I_SCLK),
    .I_SS_N     (I_SS_N),
    .I_MOSI     (I_MOSI),
    .O_MISO     (O_MISO),
    .I_TX_DATA  (I_TX_DATA),
    .I_TX_LOAD  (I_TX_LOAD),
    .O_TX_READY (O_TX_READY),
    .O_RX_DATA  (O_RX_DATA),
    .O_RX_VALID (O_RX_VALID),
    .I_RX_ACK   (I_RX_ACK),
    .O_OVERRUN  (O_OVERRUN),
    .O_BUSY     (O_BUSY)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word-level state of the slave as the user sees it.
  bit           m_full;
  logic [W-1:0] m_hold;
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           m_over;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_reset();
    m_full  = 1'b0;
    m_hold  = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_over  = 1'b0;
  endtask

  // Holding register handed to the shift register: old word or zeros.
  task automatic m_take(output logic [W-1:0] v);
    v      = m_full ? m_hold : '0;
    m_full = 1'b0;
  endtask

  task automatic m_word_done(input logic [W-1:0] w);
`ifdef SPI_SLAVE_OVERRUN_EN
    if (m_valid) begin
      m_over = 1'b1;
    end else begin
      m_data  = w;
      m_valid = 1'b1;
    end
`else
    m_data  = w;
    m_valid = 1'b1;
`endif
  endtask

  task automatic tx_load(input logic [W-1:0] v);
    I_TX_DATA = v;
    I_TX_LOAD = 1'b1;
    tick(1);
    I_TX_LOAD = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_hold = v;
    end
  endtask

  task automatic rx_ack();
    I_RX_ACK = 1'b1;
    tick(1);
    I_RX_ACK = 1'b0;
    m_valid = 1'b0;
    m_over  = 1'b0;
  endtask

  task automatic check_rx(input string tag);
    check_eq({tag, "_rx_valid"}, O_RX_VALID, m_valid);
    check_eq({tag, "_rx_data"},  O_RX_DATA,  m_data);
    check_eq({tag, "_overrun"},  O_OVERRUN,  m_over);
  endtask

  // Clock out nbits of one word, MSB first. Each half period is 8 I_CLK.
  // MISO is sampled just before each rising SCLK edge, as a master would.
  task automatic spi_bits(input logic [W-1:0] mo, input int nbits, input bit do_reload,
                          input logic [W-1:0] rv, output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      I_MOSI = mo[W-1-i];
      if (i == 0 && do_reload) begin
        tick(5);
        check_eq("tx_ready_after_xfer", O_TX_READY, 1'b1);
        tx_load(rv);
        tick(2);
      end else begin
        tick(8);
      end
      mi[W-1-i] = O_MISO;
      I_SCLK = 1'b1;
      tick(8);
      I_SCLK = 1'b0;
    end
  endtask

  task automatic run_frame(input string name, input int nwords, input logic [2:0][W-1:0] mo,
                           input logic [2:0] ack_en, input logic [2:0] reload_en,
                           input logic [2:0][W-1:0] rv, input int abort_bits);
    logic [W-1:0] exp_tx;
    logic [W-1:0] got_tx;
    logic [W-1:0] junk;
    string        line;
    line = "";
    I_SS_N = 1'b0;
    m_take(exp_tx);
    for (int w = 0; w < nwords; w++) begin
      spi_bits(mo[w], W, reload_en[w], rv[w], got_tx);
      check_eq("miso_word", got_tx, exp_tx);
      line = {line, $sformatf(" mosi=%02h miso=%02h(exp %02h)", mo[w], got_tx, exp_tx)};
      m_word_done(mo[w]);
      m_take(exp_tx);
      tick(6);
      check_rx("word");
      check_eq("busy_in_frame", O_BUSY, 1'b1);
      check_eq("tx_ready_in_frame", O_TX_READY, !m_full);
      if (ack_en[w]) rx_ack();
    end
    if (abort_bits > 0) begin
      spi_bits(W'($urandom), abort_bits, 1'b0, '0, junk);
      line = {line, $sformatf(" abort after %0d bits", abort_bits)};
    end
    tick(6);
    I_SS_N = 1'b1;
    tick(10);
    check_eq("busy_idle", O_BUSY, 1'b0);
    check_eq("miso_idle", O_MISO, 1'b0);
    check_eq("tx_ready_idle", O_TX_READY, !m_full);
    check_rx("end");
    $display("frame %s: words=%0d%s rx_valid=%0b rx_data=%02h overrun=%0b",
             name, nwords, line, O_RX_VALID, O_RX_DATA, O_OVERRUN);
  endtask

  initial begin
    logic [W-1:0] junk;
    I_RESET   = 1'b1;
    I_SCLK    = 1'b0;
    I_SS_N    = 1'b1;
    I_MOSI    = 1'b0;
    I_TX_DATA = '0;
    I_TX_LOAD = 1'b0;
    I_RX_ACK  = 1'b0;
    m_reset();
    tick(4);
    I_RESET = 1'b0;
    tick(10);
    check_eq("reset_miso", O_MISO, 1'b0);
    check_eq("reset_tx_ready", O_TX_READY, 1'b1);
    check_eq("reset_busy", O_BUSY, 1'b0);
    check_rx("reset");

    // Single frame with a preloaded word
    tx_load(8'hA5);
    check_eq("tx_ready_after_load", O_TX_READY, 1'b0);
    run_frame("single", 1, {8'h00, 8'h00, 8'h3C}, 3'b000, 3'b000, '0, 0);
    check_eq("single_rx_data", O_RX_DATA, 8'h3C);
    rx_ack();
    check_eq("ack_clears_valid", O_RX_VALID, 1'b0);

    // Back-to-back words, reload while the first word is shifting
    tx_load(8'h11);
    run_frame("b2b", 2, {8'h00, 8'h0F, 8'hF0}, 3'b011, 3'b001, {8'h00, 8'h00, 8'h22}, 0);

    // Empty holding register returns zeros
    run_frame("empty_tx", 1, {8'h00, 8'h00, 8'h5A}, 3'b001, 3'b000, '0, 0);

    // Abort mid-word leaves RX untouched, next frame is normal
    run_frame("abort", 0, '0, 3'b000, 3'b000, '0, 5);
    check_eq("abort_no_valid", O_RX_VALID, 1'b0);
    run_frame("after_abort", 1, {8'h00, 8'h00, 8'hC3}, 3'b001, 3'b000, '0, 0);

    // Two unacknowledged words
    run_frame("overrun", 2, {8'h00, 8'hAA, 8'h55}, 3'b000, 3'b000, '0, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check_eq("overrun_keeps_old", O_RX_DATA, 8'h55);
    check_eq("overrun_flag", O_OVERRUN, 1'b1);
`else
    check_eq("overwrite_new", O_RX_DATA, 8'hAA);
    check_eq("overrun_tied_off", O_OVERRUN, 1'b0);
`endif
    rx_ack();
    check_eq("ack_valid_cleared", O_RX_VALID, 1'b0);
    check_eq("ack_overrun_cleared", O_OVERRUN, 1'b0);

    // Reset in the middle of a frame
    tx_load(8'h96);
    I_SS_N = 1'b0;
    spi_bits(8'hE7, 3, 1'b0, '0, junk);
    I_RESET = 1'b1;
    tick(1);
    I_RESET = 1'b0;
    m_reset();
    tick(2);
    check_eq("midrst_miso", O_MISO, 1'b0);
    check_eq("midrst_tx_ready", O_TX_READY, 1'b1);
    check_eq("midrst_busy", O_BUSY, 1'b0);
    check_rx("midrst");
    I_SS_N = 1'b1;
    tick(10);
    tx_load(8'h69);
    run_frame("after_reset", 1, {8'h00, 8'h00, 8'h81}, 3'b001, 3'b000, '0, 0);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      logic [2:0][W-1:0] mo;
      logic [2:0][W-1:0] rv;
      int nw;
      int ab;
      for (int k = 0; k < 3; k++) begin
        mo[k] = W'($urandom);
        rv[k] = W'($urandom);
      end
      nw = $urandom_range(1, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : 0;
      if ($urandom_range(0, 1) == 1) tx_load(W'($urandom));
      if ($urandom_range(0, 3) == 0) tx_load(W'($urandom));
      if ($urandom_range(0, 2) == 0) rx_ack();
      tick(2);
      check_eq("rand_tx_ready", O_TX_READY, !m_full);
      run_frame($sformatf("rand%0d", f), nw, mo, 3'($urandom), 3'($urandom), rv, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_link.md
# spi_slave_link

SPI mode-0 slave endpoint: the far end of the SPI master bus that our master controller drives. Oversamples SCLK/SS_N/MOSI in the system clock domain and shifts one DATA_WIDTH-bit word in each direction per frame, MSB first. Exposes a holding-register transmit handshake and a received-word valid/ack handshake to local user logic.

## Interface
- DATA_WIDTH, 8: word width in bits, legal range 4..16.
- I_CLK  in  1  system clock. All logic is on the rising edge.
- I_RESET  in  1  reset, synchronous and active-high.
- I_SCLK  in  1  SPI clock from master, asynchronous; idle low (CPOL=0).
- I_SS_N  in  1  slave select, active low, asynchronous.
- I_MOSI  in  1  master-out data, asynchronous.
- O_MISO  out  1  slave-out data. Registered.
- I_TX_DATA  in  DATA_WIDTH  word to return to master.
- I_TX_LOAD  in  1  one-cycle write strobe for I_TX_DATA.
- O_TX_READY  out  1  TX holding register empty.
- O_RX_DATA  out  DATA_WIDTH  last completed received word, held.
- O_RX_VALID  out  1  O_RX_DATA unread. Level signal.
- I_RX_ACK  in  1  one-cycle strobe that clears O_RX_VALID.
- O_OVERRUN  out  1  sticky overrun flag. See Configuration.
- O_BUSY  out  1  frame in progress (synchronized SS_N low).

## Operation
- Each of SCLK, SS_N and MOSI passes through a 2-flop synchronizer, then through one history flop used for edge detection. MOSI uses the same depth, so the synchronized MOSI is aligned with the synchronized SCLK.
- FSM states:
  - IDLE: SS_N high. O_MISO=0, bit counter=0.
  - SHIFT: entered on a detected SS_N fall; returns to IDLE on a detected SS_N rise.
- On entry to SHIFT:
  - If the holding register is full, load it into the TX shift register and set O_TX_READY=1.
  - If it is empty, load all-zeros.
  - O_MISO = TX shift MSB.
- Detected SCLK rise in SHIFT: shift synchronized MOSI into the RX shift register LSB and increment the bit counter.
- Detected SCLK fall in SHIFT:
  - Bit counter != 0: shift the TX register left by one; O_MISO = new MSB.
  - Bit counter == 0 (word boundary, only after at least one full word): reload the TX register from holding (zeros if empty), same as on SHIFT entry.
- Word completion, on the DATA_WIDTH-th rise: counter wraps to 0, O_RX_DATA gets the assembled word, O_RX_VALID=1. Back-to-back words within one frame are supported.
- SS_N rises mid-word: the partial word is discarded, O_RX_VALID is unchanged, the counter clears and the state returns to IDLE. The TX holding register is untouched.
- TX handshake:
  - I_TX_LOAD with O_TX_READY=1 captures I_TX_DATA and sets O_TX_READY=0.
  - I_TX_LOAD with O_TX_READY=0 is ignored.
  - If I_TX_LOAD arrives in the same cycle as a holding-to-shift transfer, the old holding value is transferred, the new value is captured, and O_TX_READY stays 0.
- RX handshake:
  - I_RX_ACK clears O_RX_VALID.
  - If I_RX_ACK coincides with a word completion, the new word wins: O_RX_VALID stays 1.
- Reset values: O_MISO=0, O_TX_READY=1, O_RX_DATA=0, O_RX_VALID=0, O_OVERRUN=0, O_BUSY=0. The FSM goes to IDLE and the shift registers, counter and synchronizers clear. Reset mid-frame aborts the frame; the block resyncs on the next SS_N fall.

## Timing
- Pin-to-detect latency is 3 I_CLK cycles for SCLK, SS_N and MOSI.
- O_MISO updates 1 cycle after a detected SS_N fall or SCLK fall, i.e. 4 cycles after the pin edge.
- Requirement on the master: each SCLK high and low phase is at least 6 I_CLK cycles, and the SS_N-fall-to-first-SCLK-rise time is at least 6 I_CLK cycles. Equivalently, I_CLK ≥ 12× SCLK.
- O_RX_VALID asserts 1 cycle after the detected final SCLK rise, 4 cycles after the pin edge.
- O_TX_READY returns to 1 in the same cycle that O_MISO presents the new word's MSB.
- O_BUSY follows the synchronized SS_N with 3 cycles of latency.

## Configuration
- Macro: SPI_SLAVE_OVERRUN_EN.
- Defined:
  - A word completing while O_RX_VALID=1 sets O_OVERRUN=1 and leaves O_RX_DATA at the old unread word; the new word is dropped.
  - I_RX_ACK clears both O_RX_VALID and O_OVERRUN.
- Undefined:
  - The new word overwrites O_RX_DATA unconditionally.
  - O_OVERRUN is tied to 0.

## Test plan
- Single frame, SCLK = I_CLK/16:
  - Stimulus: I_TX_LOAD 8'hA5 while idle, then master sends 8'h3C.
  - Response: master receives 8'hA5; O_RX_DATA=8'h3C with O_RX_VALID=1; O_TX_READY=1 after SS_N fall.
- Back-to-back words in one frame:
  - Stimulus: preload 8'h11, reload 8'h22 when O_TX_READY rises; master sends 8'hF0 then 8'h0F.
  - Response: master receives 8'h11 then 8'h22; two O_RX_VALID events with acks in between.
- Empty TX:
  - Stimulus: frame with no I_TX_LOAD.
  - Response: master receives 8'h00; the RX word is still captured correctly.
- Abort:
  - Stimulus: SS_N rises after 5 SCLK rises.
  - Response: O_RX_VALID stays 0; the next full frame receives its word correctly.
- Overrun (macro on):
  - Stimulus: two words 8'h55 and 8'hAA with no ack.
  - Response: O_RX_DATA=8'h55, O_OVERRUN=1; after I_RX_ACK both flags are 0.
  - Same stimulus with macro off: O_RX_DATA=8'hAA, O_OVERRUN=0.
- Reset mid-frame:
  - Stimulus: I_RESET asserted for 1 cycle after 3 bits.
  - Response: all outputs at reset values; the next frame completes normally.
